// File: rtl/i2s_pkg.sv
// Shared I2S types and constants used by the receive (and transmit) cores.
package i2s_pkg;

    // Default number of bits captured per channel.
    localparam int I2S_SAMPLE_BITS_DEFAULT = 16;

    // Receiver framing state: SYNC waits for the first WS transition, RUN captures words.
    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } rx_state_t;

    // Stereo pair as exchanged with the transmitter: left in the upper half.
    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } i2s_pair_t;

endpackage

// File: rtl/i2s_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous single-bit inputs.
module i2s_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops give metastability time before the value is used.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= async_i;
            r_sync <= r_meta;
        end
    end

    assign sync_o = r_sync;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples BCLK/WS/SD in the system clock domain,
// deserialises MSB-first left/right words and emits {left, right} pairs on a
// valid/ready stream, flagging dropped pairs and short words.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_BITS = I2S_SAMPLE_BITS_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i2s_bclk_i,
    input  logic                     i2s_ws_i,
    input  logic                     i2s_data_i,
    output logic [2*SAMPLE_BITS-1:0] sample_o,
    output logic                     sample_valid_o,
    input  logic                     sample_ready_i,
    output logic                     overflow_o,
    output logic                     len_err_o
);

    localparam int CW = $clog2(SAMPLE_BITS + 1);
    localparam logic [CW-1:0] FULL = CW'(SAMPLE_BITS);

    logic [2:0]             w_sync;
    logic                   w_bclk_s;
    logic                   w_ws_s;
    logic                   w_sd_s;
    logic                   w_edge;
    logic                   w_transition;
    logic                   w_take;
    logic [CW-1:0]          w_cnt_next;
    logic [SAMPLE_BITS-1:0] w_shift_next;
    logic                   w_word_end;
    logic                   w_short;
    logic                   w_pair_done;

    logic                     r_bclk_d;
    logic                     r_ws_prev;
    rx_state_t                r_state;
    logic [CW-1:0]            r_cnt;
    logic [SAMPLE_BITS-1:0]   r_shift;
    logic [SAMPLE_BITS-1:0]   r_left;
    logic                     r_left_valid;
    logic [2*SAMPLE_BITS-1:0] r_sample;
    logic                     r_valid;
    logic                     r_overflow;
    logic                     r_len_err;

    // All three bus lines share one synchroniser so they stay aligned to each other.
    i2s_sync #(
        .WIDTH(3)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i({i2s_data_i, i2s_ws_i, i2s_bclk_i}),
        .sync_o (w_sync)
    );

    assign w_bclk_s = w_sync[0];
    assign w_ws_s   = w_sync[1];
    assign w_sd_s   = w_sync[2];

    // Rising BCLK is the only moment WS/SD are meaningful; a WS change there ends a word.
    assign w_edge       = w_bclk_s & ~r_bclk_d;
    assign w_transition = w_edge & (w_ws_s != r_ws_prev);

    // Bits beyond SAMPLE_BITS in a slot are padding, so the counter saturates.
    assign w_take       = (r_cnt < FULL);
    assign w_cnt_next   = w_take ? (r_cnt + 1'b1) : r_cnt;
    assign w_shift_next = w_take ? {r_shift[SAMPLE_BITS-2:0], w_sd_s} : r_shift;

    // The transition edge still carries the LSB of the ending word, hence the *_next values.
    assign w_word_end  = (r_state == RUN) & w_transition;
    assign w_short     = w_word_end & (w_cnt_next < FULL);
    assign w_pair_done = w_word_end & ~w_short & r_ws_prev & r_left_valid;

    // Framing FSM plus word assembly: counter, shift register and left holding register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bclk_d     <= 1'b0;
            r_ws_prev    <= 1'b0;
            r_state      <= SYNC;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_left       <= '0;
            r_left_valid <= 1'b0;
        end else begin
            r_bclk_d <= w_bclk_s;
            if (w_edge) begin
                r_ws_prev <= w_ws_s;
                case (r_state)
                    SYNC: begin
                        if (w_transition) begin
                            r_state <= RUN;
                            r_cnt   <= '0;
                            r_shift <= '0;
                        end
                    end
                    RUN: begin
                        if (w_transition) begin
                            r_cnt   <= '0;
                            r_shift <= '0;
                            if (w_short) begin
                                if (!r_ws_prev) begin
                                    r_left_valid <= 1'b0;
                                end
                            end else if (!r_ws_prev) begin
                                r_left       <= w_shift_next;
                                r_left_valid <= 1'b1;
                            end else if (r_left_valid) begin
                                r_left_valid <= 1'b0;
                            end
                        end else begin
                            r_cnt   <= w_cnt_next;
                            r_shift <= w_shift_next;
                        end
                    end
                    default: r_state <= SYNC;
                endcase
            end
        end
    end

    // Output stage: a pending pair is never overwritten; a new pair either loads or is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            r_len_err  <= w_short;
            if (r_valid && sample_ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_pair_done) begin
                if (!r_valid || sample_ready_i) begin
                    r_sample <= {r_left, w_shift_next};
                    r_valid  <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign sample_o       = r_sample;
    assign sample_valid_o = r_valid;
    assign overflow_o     = r_overflow;
    assign len_err_o      = r_len_err;

endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S slave receiver: samples an externally driven I2S bus (BCLK, WS, SD from an ADC or codec master) in the system clock domain, deserialises MSB-first left/right words, and presents each stereo pair as one 32-bit word on a valid/ready stream. It is the capture-side counterpart of the `i2s` master transmitter and produces pairs in that core's `sample_i` format, `{left[15:0], right[15:0]}`, so captured audio can be looped back or fed to the DAC path unchanged.

## Interface
Parameters:
- `SAMPLE_BITS`, 16, bits captured per channel; MSB-justified; max 32.

Ports:
- `clk_i`  in  1  system clock; one clock; each BCLK high and low phase ≥ 2 `clk_i` periods.
- `rst_i`  in  1  reset; synchronous, active-high.
- `i2s_bclk_i`  in  1  bit clock, asynchronous.
- `i2s_ws_i`  in  1  word select, asynchronous: 0 = left, 1 = right.
- `i2s_data_i`  in  1  serial data, asynchronous.
- `sample_o`  out  2*SAMPLE_BITS  `{left, right}`.
- `sample_valid_o`  out  1  pair available.
- `sample_ready_i`  in  1  consumer accepts.
- `overflow_o`  out  1  one-cycle pulse: completed pair dropped.
- `len_err_o`  out  1  one-cycle pulse: word shorter than SAMPLE_BITS discarded.

## Operation
- Reset values: `sample_o`=0, `sample_valid_o`=0, `overflow_o`=0, `len_err_o`=0. State=SYNC, bit counter=0, left-valid flag=0, synchroniser flops=0.
- BCLK, WS and SD each pass through an identical 2-flop synchroniser. `bclk_d` is the synchronised BCLK delayed one cycle. Edge cycle = `bclk_s & ~bclk_d`. WS and SD are sampled only in edge cycles. `ws_prev` holds WS from the previous edge.
- Transition edge: an edge cycle in which `ws_s != ws_prev`. Per I2S, this edge carries the LSB of the word just ending. The next edge carries the MSB of the new word.
- States:
  - SYNC: ignore data until the first transition edge, then go to RUN with bit counter=0. This discards the partial word after reset.
  - RUN: on every edge, if counter < SAMPLE_BITS, shift SD into the word shift register (MSB-first) and increment the counter. The counter saturates at SAMPLE_BITS, so extra slot bits are ignored.
- On a transition edge in RUN, the word is complete, including that edge's bit:
  - counter (after this edge's increment) < SAMPLE_BITS: pulse `len_err_o` and discard the word. If the word was left (`ws_prev`=0), clear the left-valid flag.
  - old channel left: store the word in the left holding register and set left-valid.
  - old channel right with left-valid=1: form the pair `{left, word}` and clear left-valid.
  - old channel right with left-valid=0: discard silently.
  - In all cases, reset the counter to 0 and clear the shift register.
- Pair output:
  - `sample_valid_o`=0, or `sample_ready_i`=1 in the same cycle: load `sample_o` and set valid.
  - `sample_valid_o`=1 and `sample_ready_i`=0: keep the old pair, drop the new one, and pulse `overflow_o`.
- Handshake: the transfer occurs on a cycle where valid & ready are both 1. Valid then drops the next cycle unless a new pair loads in that same cycle. `sample_o` is stable while valid=1 and ready=0.
- `rst_i` mid-frame: everything returns to reset values and SYNC. A partially received pair is never output.

## Timing
- Synchroniser latency: 2 cycles. Edge cycle: the 3rd rising `clk_i` edge after BCLK is first seen high.
- `sample_valid_o`, `sample_o` and the pulse outputs are registered and assert 1 cycle after the edge cycle of the right-channel transition edge.
- Throughput: one pair per LRCLK frame. No bubble is required between consecutive accepted pairs.
- The minimum supported frame is 2×SAMPLE_BITS BCLKs. Shorter channel slots raise `len_err_o`.

## Structure
- Package `i2s_pkg`:
  - `rx_state_t` enum {SYNC, RUN}.
  - `I2S_SAMPLE_BITS_DEFAULT`=16.
  - Pair type `i2s_pair_t` as packed `{left, right}`, shared with the transmitter.
- Sub-module `i2s_sync`: a parameterised-width 2-flop synchroniser, instantiated once with width 3 for BCLK/WS/SD.
- Everything else lives in a single `i2s_rx` body: edge detect, counter, shift register, holding register, output register.

## Test plan
- 16-BCLK slots, ready tied 1: L=0xA5A5, R=0x5A5A → `sample_o`=0xA5A55A5A, one valid pulse per frame, no error pulses.
- 32-BCLK slots, L=0x1234 followed by 16 junk bits, R=0xBEEF followed by 16 junk bits → `sample_o`=0x1234BEEF; the junk bits are ignored.
- Ready held 0 across two frames → the first pair is held stable, `overflow_o` pulses once at the second frame, and the first pair is delivered when ready rises.
- Left slot of 12 BCLKs → `len_err_o` pulses and that frame produces no valid. The next well-formed frame outputs normally.
- Reset released mid-frame → the partial word is discarded, and the first output is the first complete L/R pair after the first WS transition.
- Ready=1 in the same cycle a new pair completes → the old pair transfers, the new pair loads with no overflow, and valid stays high.
